// File: rtl/types_pkg.sv
// Shared encodings for the I2C master engine: host commands, bus direction and engine states.
package types_pkg;

  typedef enum logic [2:0] {
    CMD_START     = 3'd0,
    CMD_STOP      = 3'd1,
    CMD_WRITE     = 3'd2,
    CMD_READ_ACK  = 3'd3,
    CMD_READ_NACK = 3'd4
  } i2c_cmd_t;

  // Direction of a byte transfer; also the R/W bit of an address byte.
  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } i2c_op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_STOP  = 3'd2,
    S_XFER  = 3'd3,
    S_DONE  = 3'd4
  } eng_state_t;

  localparam logic [3:0] LAST_BIT = 4'd8;   // ninth bit of a byte frame (ACK slot)
  localparam logic [1:0] Q_SAMPLE = 2'd1;
  localparam logic [1:0] Q_LAST   = 2'd3;

  // STOP and byte transfers only make sense while the engine owns the bus.
  function automatic logic cmd_is_legal(input i2c_cmd_t c, input logic bus_owned);
    logic ok;
    case (c)
      CMD_START:                                         ok = 1'b1;
      CMD_STOP, CMD_WRITE, CMD_READ_ACK, CMD_READ_NACK:  ok = bus_owned;
      default:                                           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit timebase: one-cycle tick every CLK_DIV clocks, restarted by reset.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 25
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LOAD = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == '0);

  // Down-counter reloads on terminal count so ticks are exactly CLK_DIV apart.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= LOAD;
    end else if (tick) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_engine.sv
// Byte-level I2C master: executes START/STOP/WRITE/READ commands one at a time,
// splitting every bit into four quarters timed by i2c_quarter_tick.
//
// state   | meaning
// IDLE    | waiting for a command; divider held in reset
// START   | four quarters of a (repeated) start condition
// STOP    | four quarters of a stop condition
// XFER    | nine bits of a byte frame (8 data + ACK slot)
// DONE    | one-cycle completion pulse, responses valid
module i2c_master_engine
  import types_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  i2c_cmd_t   cmd,
  input  logic [7:0] cmd_data,
  output logic       done,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       rsp_err,
  output logic       bus_active,
  output logic       scl_o,
  output logic       sda_oe,
  input  logic       sda_i
);

  eng_state_t state, state_n;
  logic [1:0] quarter, quarter_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic       tick, div_rst, accept, legal, q_end, bit_drive;
  logic [7:0] tx_sh, rx_sh;
  logic       ack_smp, sda_last, read_ack;
  i2c_op_t    xfer_op;

  assign div_rst = rst_i || (state == S_IDLE);

  i2c_quarter_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_quarter_tick (
    .clk_i(clk_i),
    .rst_i(div_rst),
    .tick (tick)
  );

  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = cmd_is_legal(cmd, bus_active);
  assign q_end     = tick && (quarter == Q_LAST);

  always_comb begin
    state_n   = state;
    quarter_n = quarter;
    bit_cnt_n = bit_cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!legal) begin
            state_n = S_DONE;
          end else if (cmd == CMD_START) begin
            state_n = S_START;
          end else if (cmd == CMD_STOP) begin
            state_n = S_STOP;
          end else begin
            state_n = S_XFER;
          end
        end
      end
      S_START, S_STOP: begin
        if (tick) begin
          quarter_n = quarter + 2'd1;
          if (quarter == Q_LAST) begin
            state_n = S_DONE;
          end
        end
      end
      S_XFER: begin
        if (tick) begin
          quarter_n = quarter + 2'd1;
          if (quarter == Q_LAST) begin
            if (bit_cnt == LAST_BIT) begin
              state_n   = S_DONE;
              bit_cnt_n = '0;
            end else begin
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // tx_sh and bit_cnt only move at the end of Q3, so SDA changes only as Q0 begins.
  always_comb begin
    if (bit_cnt != LAST_BIT) begin
      bit_drive = (xfer_op == OP_WRITE) && !tx_sh[7];
    end else begin
      bit_drive = (xfer_op == OP_READ) && read_ack;
    end
  end

  always_comb begin
    scl_o  = !bus_active;
    sda_oe = bus_active && sda_last;
    case (state)
      S_START: begin
        scl_o  = (quarter == 2'd1) || (quarter == 2'd2);
        sda_oe = quarter[1];
      end
      S_STOP: begin
        scl_o  = (quarter != 2'd0);
        sda_oe = !quarter[1];
      end
      S_XFER: begin
        scl_o  = (quarter == 2'd1) || (quarter == 2'd2);
        sda_oe = bit_drive;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      quarter    <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      ack_smp    <= 1'b0;
      sda_last   <= 1'b0;
      read_ack   <= 1'b0;
      xfer_op    <= OP_WRITE;
      bus_active <= 1'b0;
      rsp_data   <= '0;
      rsp_nack   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state   <= state_n;
      quarter <= quarter_n;
      bit_cnt <= bit_cnt_n;

      // Remembered so an owned-but-idle bus keeps SDA where the last command left it.
      if ((state == S_START) || (state == S_STOP) || (state == S_XFER)) begin
        sda_last <= sda_oe;
      end

      if (accept) begin
        tx_sh    <= cmd_data;
        xfer_op  <= (cmd == CMD_WRITE) ? OP_WRITE : OP_READ;
        read_ack <= (cmd == CMD_READ_ACK);
        if (!legal) begin
          rsp_err  <= 1'b1;
          rsp_nack <= 1'b0;
          rsp_data <= '0;
        end
      end

      if (((state == S_START) || (state == S_STOP)) && q_end) begin
        bus_active <= (state == S_START);
        rsp_err    <= 1'b0;
        rsp_nack   <= 1'b0;
        rsp_data   <= '0;
      end

      if ((state == S_XFER) && tick) begin
        if (quarter == Q_SAMPLE) begin
          if (bit_cnt != LAST_BIT) begin
            rx_sh <= {rx_sh[6:0], sda_i};
          end else begin
            ack_smp <= sda_i;
          end
        end
        if (quarter == Q_LAST) begin
          tx_sh <= {tx_sh[6:0], 1'b0};
          if (bit_cnt == LAST_BIT) begin
            rsp_err  <= 1'b0;
            rsp_nack <= (xfer_op == OP_WRITE) && ack_smp;
            rsp_data <= (xfer_op == OP_READ) ? rx_sh : 8'h00;
          end
        end
      end
    end
  end

endmodule
